// File: rtl/stepdown_corestate_ctrl_pkg.sv
// Shared state encoding and default constants for the step-down core-state controller.
package stepdown_pkg;

  typedef enum logic [1:0] {
    ST_OFF       = 2'b00,
    ST_SOFTSTART = 2'b01,
    ST_RUN       = 2'b10,
    ST_FAULT     = 2'b11
  } state_e;

  localparam int unsigned CNT_W_DEF       = 8;
  localparam int unsigned DEAD_CYC_DEF    = 4;
  localparam int unsigned SS_STEP_CYC_DEF = 64;
  localparam int unsigned RETRY_CYC_DEF   = 1024;

endpackage

// File: rtl/stepdown_corestate_ctrl_deadtime.sv
// Complementary gate-drive generator: inserts DEAD_CYC blank clocks on every raw edge
// and whenever force_off is seen; hs_on and ls_on can never be high together.
module stepdown_deadtime
  import stepdown_pkg::*;
#(
  parameter int unsigned DEAD_CYC = DEAD_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic force_off,
  output logic hs_on,
  output logic ls_on
);

  localparam int unsigned DW = $clog2(DEAD_CYC + 1);

  logic [DW-1:0] dead_q, dead_d;
  logic          raw_prev_q, raw_prev_d;
  logic          hs_q, hs_d;
  logic          ls_q, ls_d;

  // Both sides are only ever driven from opposite polarities of raw, so exclusivity is structural.
  always_comb begin
    raw_prev_d = raw;
    dead_d     = dead_q;
    hs_d       = 1'b0;
    ls_d       = 1'b0;
    if (force_off || (raw != raw_prev_q)) begin
      dead_d = DW'(DEAD_CYC - 1);
    end else if (dead_q != '0) begin
      dead_d = dead_q - DW'(1);
    end else begin
      hs_d = raw;
      ls_d = ~raw;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dead_q     <= '0;
      raw_prev_q <= 1'b0;
      hs_q       <= 1'b0;
      ls_q       <= 1'b0;
    end else begin
      dead_q     <= dead_d;
      raw_prev_q <= raw_prev_d;
      hs_q       <= hs_d;
      ls_q       <= ls_d;
    end
  end

  assign hs_on = hs_q;
  assign ls_on = ls_q;

endmodule

// File: rtl/stepdown_corestate_ctrl.sv
// Buck core-state controller: OFF/SOFTSTART/RUN/FAULT sequencing, PWM counter and soft-start ramp.
// Define STEPDOWN_FAULT_RETRY_EN to auto-retry from FAULT after RETRY_CYC clocks with ocp low.
module stepdown_corestate_ctrl
  import stepdown_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned DEAD_CYC    = DEAD_CYC_DEF,
  parameter int unsigned SS_STEP_CYC = SS_STEP_CYC_DEF,
  parameter int unsigned RETRY_CYC   = RETRY_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] duty_cmd,
  input  logic             ocp,
  output logic             hs_on,
  output logic             ls_on,
  output logic [1:0]       state,
  output logic             ss_done,
  output logic             fault
);

  localparam int unsigned TW = (SS_STEP_CYC > 1) ? $clog2(SS_STEP_CYC) : 1;

  if (DEAD_CYC == 0 || SS_STEP_CYC == 0 || RETRY_CYC == 0 || CNT_W < 2) begin : g_bad_cfg
    $error("stepdown_corestate_ctrl: illegal parameter set");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_l_q, period_l_d;
  logic [CNT_W-1:0] duty_l_q, duty_l_d;
  logic [CNT_W-1:0] ss_duty_q, ss_duty_d;
  logic [TW-1:0]    ss_tick_q, ss_tick_d;
  logic             ss_done_q, ss_done_d;
  logic             fault_q, fault_d;

  logic [CNT_W-1:0] ss_limit, duty_eff;
  logic             raw, force_off, active_q, active_d, short_period, wrap;
  logic             retry_due;

`ifdef STEPDOWN_FAULT_RETRY_EN
  localparam int unsigned RW = (RETRY_CYC > 1) ? $clog2(RETRY_CYC) : 1;
  logic [RW-1:0] retry_q, retry_d;

  // Hold-off counter wraps on completion, so a still-high ocp simply restarts the wait.
  always_comb begin
    retry_d = retry_q;
    if (state_d == ST_FAULT && state_q != ST_FAULT) begin
      retry_d = '0;
    end else if (state_q == ST_FAULT) begin
      retry_d = (retry_q == RW'(RETRY_CYC - 1)) ? '0 : retry_q + RW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retry_q <= '0;
    else        retry_q <= retry_d;
  end

  assign retry_due = (retry_q == RW'(RETRY_CYC - 1)) && !ocp;
`else
  assign retry_due = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF:       if (en) state_d = ST_SOFTSTART;
      ST_SOFTSTART: begin
        if (!en)                          state_d = ST_OFF;
        else if (ocp)                     state_d = ST_FAULT;
        else if (ss_duty_q >= duty_l_q)   state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!en)      state_d = ST_OFF;
        else if (ocp) state_d = ST_FAULT;
      end
      ST_FAULT: begin
        if (!en)            state_d = ST_OFF;
        else if (retry_due) state_d = ST_SOFTSTART;
      end
      default: state_d = ST_OFF;
    endcase
  end

  always_comb begin
    ss_limit = '0;
    if (state_q == ST_RUN)            ss_limit = '1;
    else if (state_q == ST_SOFTSTART) ss_limit = ss_duty_q;
    duty_eff = duty_l_q;
    if (ss_limit < duty_eff)   duty_eff = ss_limit;
    if (period_l_q < duty_eff) duty_eff = period_l_q;
    raw = (cnt_q < duty_eff);

    // Leaving the switching states kills the drives on the very next clock.
    active_q     = (state_q == ST_SOFTSTART) || (state_q == ST_RUN);
    active_d     = (state_d == ST_SOFTSTART) || (state_d == ST_RUN);
    short_period = (period_l_q < CNT_W'(2));
    force_off    = !(active_q && active_d) || short_period ||
                   (state_q == ST_SOFTSTART && ss_duty_q == '0);

    wrap       = !active_q || short_period || (cnt_q == period_l_q - CNT_W'(1));
    cnt_d      = wrap ? '0 : cnt_q + CNT_W'(1);
    period_l_d = wrap ? period : period_l_q;
    duty_l_d   = wrap ? duty_cmd : duty_l_q;

    ss_duty_d = ss_duty_q;
    ss_tick_d = ss_tick_q;
    if (state_d == ST_SOFTSTART && state_q != ST_SOFTSTART) begin
      ss_duty_d = '0;
      ss_tick_d = '0;
    end else if (state_q == ST_SOFTSTART) begin
      if (ss_tick_q == TW'(SS_STEP_CYC - 1)) begin
        ss_tick_d = '0;
        ss_duty_d = (ss_duty_q >= duty_l_q) ? duty_l_q : ss_duty_q + CNT_W'(1);
      end else begin
        ss_tick_d = ss_tick_q + TW'(1);
      end
    end

    ss_done_d = (state_d == ST_RUN);
    fault_d   = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_OFF;
      cnt_q      <= '0;
      period_l_q <= '0;
      duty_l_q   <= '0;
      ss_duty_q  <= '0;
      ss_tick_q  <= '0;
      ss_done_q  <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      period_l_q <= period_l_d;
      duty_l_q   <= duty_l_d;
      ss_duty_q  <= ss_duty_d;
      ss_tick_q  <= ss_tick_d;
      ss_done_q  <= ss_done_d;
      fault_q    <= fault_d;
    end
  end

  stepdown_deadtime #(
    .DEAD_CYC (DEAD_CYC)
  ) u_deadtime (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw       (raw),
    .force_off (force_off),
    .hs_on     (hs_on),
    .ls_on     (ls_on)
  );

  assign state   = state_q;
  assign ss_done = ss_done_q;
  assign fault   = fault_q;

endmodule

// File: tb/tb_stepdown_corestate_ctrl.sv
// Self-checking bench for stepdown_corestate_ctrl: cycle model plus directed literal checks.
module tb_stepdown_corestate_ctrl;

  localparam int D     = 4;
  localparam int STEP  = 2;
  localparam int RETRY = 16;
`ifdef STEPDOWN_FAULT_RETRY_EN
  localparam bit RETRY_ON = 1'b1;
`else
  localparam bit RETRY_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       ocp = 1'b0;
  logic [7:0] period = 8'd0;
  logic [7:0] duty_cmd = 8'd0;
  logic       hs_on, ls_on, ss_done, fault;
  logic [1:0] state;

  int n_checks = 0;
  int n_fail   = 0;
  bit gap_en   = 1'b0;

  always #5 clk = ~clk;

  stepdown_corestate_ctrl #(
    .CNT_W       (8),
    .DEAD_CYC    (D),
    .SS_STEP_CYC (STEP),
    .RETRY_CYC   (RETRY)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .period   (period),
    .duty_cmd (duty_cmd),
    .ocp      (ocp),
    .hs_on    (hs_on),
    .ls_on    (ls_on),
    .state    (state),
    .ss_done  (ss_done),
    .fault    (fault)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: st 0..3, age = clocks spent in SOFTSTART, fage = clocks spent in FAULT,
  // last_ev = most recent cycle whose raw edge or forced-off condition blanks the drives.
  typedef struct {
    int st, cnt, per, duty, age, fage, prev_raw, cyc, last_ev, hs, ls;
  } mdl_t;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r = '{default: 0};
    r.last_ev = -1000;
    return r;
  endfunction

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m, input bit en_i, input bit ocp_i,
                                    input int per_i, input int duty_i);
    mdl_t n;
    int ns, ss, lim, eff, raw;
    bit live, frc;
    n  = m;
    ss = m.age / STEP;
    ns = m.st;
    if (m.st == 0)                      ns = en_i ? 1 : 0;
    else if (!en_i)                     ns = 0;
    else if (m.st != 3 && ocp_i)        ns = 3;
    else if (m.st == 1 && ss >= m.duty) ns = 2;
    else if (m.st == 3 && RETRY_ON && (m.fage % RETRY) == RETRY - 1 && !ocp_i) ns = 1;

    lim  = (m.st == 2) ? 255 : ((m.st == 1) ? ss : 0);
    eff  = min2(min2(m.duty, lim), m.per);
    raw  = (m.cnt < eff) ? 1 : 0;
    live = (m.st == 1 || m.st == 2) && (ns == 1 || ns == 2);
    frc  = !live || m.per < 2 || (m.st == 1 && ss == 0);
    if (frc || raw != m.prev_raw) n.last_ev = m.cyc;
    n.prev_raw = raw;
    if (n.last_ev > m.cyc - D) begin
      n.hs = 0; n.ls = 0;
    end else begin
      n.hs = raw; n.ls = 1 - raw;
    end

    if (!(m.st == 1 || m.st == 2) || m.per < 2 || m.cnt == m.per - 1) begin
      n.cnt = 0; n.per = per_i; n.duty = duty_i;
    end else begin
      n.cnt = m.cnt + 1;
    end
    n.age  = (ns == 1 && m.st != 1) ? 0 : m.age + 1;
    n.fage = (ns == 3 && m.st != 3) ? 0 : m.fage + 1;
    n.st   = ns;
    n.cyc  = m.cyc + 1;
    return n;
  endfunction

  mdl_t m = mdl_reset();

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= mdl_reset();
    else        m <= mdl_step(m, en, ocp, int'(period), int'(duty_cmd));
  end

  int last_side = 0;
  int zrun = 0;

  always @(negedge clk) begin
    int side;
    check("hs_on", int'(hs_on), m.hs);
    check("ls_on", int'(ls_on), m.ls);
    check("state", int'(state), m.st);
    check("ss_done", int'(ss_done), (m.st == 2) ? 1 : 0);
    check("fault", int'(fault), (m.st == 3) ? 1 : 0);
    check("exclusive", int'(hs_on & ls_on), 0);
    if (!gap_en) begin
      last_side = 0; zrun = 0;
    end else if (hs_on || ls_on) begin
      side = hs_on ? 1 : 2;
      if (last_side != 0 && side != last_side) check("dead_gap", zrun, D);
      last_side = side; zrun = 0;
    end else begin
      zrun++;
    end
  end

  task automatic cycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  initial begin
    int cnt, hs_cnt, ls_cnt, tog, prev;
    bit hit;
    period = 8'd100; duty_cmd = 8'd40;
    cycles(3);
    #1;
    check("rst_state", int'(state), 0);
    check("rst_hs", int'(hs_on), 0);
    check("rst_ls", int'(ls_on), 0);
    check("rst_flags", int'({ss_done, fault}), 0);
    @(negedge clk); rst_n = 1'b1;
    cycles(2);
    $display("reset released, state=%0d", state);

    en = 1'b1;
    cnt = 0;
    hit = 1'b0;
    while (!hit && cnt < 200) begin
      @(negedge clk); cnt++;
      hit = ss_done;
    end
    check("ss_entry_cycles", cnt, 82);
    check("run_state", int'(state), 2);
    $display("soft-start done after %0d clocks", cnt);

    cycles(200);
    hs_cnt = 0; ls_cnt = 0;
    repeat (100) begin @(negedge clk); hs_cnt += int'(hs_on); ls_cnt += int'(ls_on); end
    check("hs_per_period", hs_cnt, 36);
    check("ls_per_period", ls_cnt, 56);
    $display("steady run: hs=%0d ls=%0d per 100 clocks", hs_cnt, ls_cnt);

    duty_cmd = 8'd100;
    cycles(250);
    hs_cnt = 0; tog = 0; prev = int'(hs_on);
    repeat (200) begin
      @(negedge clk); hs_cnt += int'(hs_on);
      if (int'(hs_on) != prev) tog++;
      prev = int'(hs_on);
    end
    check("full_duty_hs", hs_cnt, 200);
    check("full_duty_toggles", tog, 0);
    $display("duty=100: hs high %0d/200, toggles %0d", hs_cnt, tog);

    duty_cmd = 8'd0;
    cycles(250);
    ls_cnt = 0;
    repeat (200) begin @(negedge clk); ls_cnt += int'(ls_on); end
    check("zero_duty_ls", ls_cnt, 200);
    $display("duty=0: ls high %0d/200", ls_cnt);

    period = 8'd1;
    cycles(110);
    hs_cnt = 0;
    repeat (50) begin @(negedge clk); hs_cnt += int'(hs_on | ls_on); end
    check("period1_off", hs_cnt, 0);
    $display("period=1: active drive clocks %0d", hs_cnt);

    period = 8'd100;
    duty_cmd = 8'd40;
    cycles(250);
    gap_en = 1'b1;
    for (int i = 0; i < 270; i++) begin
      int d;
      d = int'($urandom_range(0, 120));
      if (d > 0 && d < 8) d = 0;
      if (d > 92 && d < 100) d = 100;
      duty_cmd = 8'(d);
      cycles(37);
    end
    gap_en = 1'b0;
    $display("random duty sweep finished, checks so far %0d", n_checks);

    duty_cmd = 8'd40;
    cycles(250);
    @(negedge clk); ocp = 1'b1;
    @(negedge clk); ocp = 1'b0;
    check("fault_hs", int'(hs_on), 0);
    check("fault_ls", int'(ls_on), 0);
    check("fault_state", int'(state), 3);
    check("fault_flag", int'(fault), 1);
    cycles(5);
    check("fault_held", int'(state), 3);
    en = 1'b0;
    @(negedge clk);
    check("off_state", int'(state), 0);
    check("off_fault", int'(fault), 0);
    $display("fault latched and cleared by en=0");

`ifdef STEPDOWN_FAULT_RETRY_EN
    en = 1'b1;
    cnt = 0; hit = 1'b0;
    while (!hit && cnt < 300) begin @(negedge clk); cnt++; hit = ss_done; end
    check("retry_run_reached", int'(hit), 1);
    ocp = 1'b1;
    cycles(30);
    check("retry_hold", int'(state), 3);
    ocp = 1'b0;
    cnt = 0; hit = 1'b0;
    while (!hit && cnt < 20) begin @(negedge clk); cnt++; hit = (state == 2'b01); end
    check("retry_resume", int'(hit), 1);
    $display("retry resumed soft-start after %0d clocks", cnt);
`endif

    en = 1'b1;
    cnt = 0; hit = 1'b0;
    while (!hit && cnt < 400) begin @(negedge clk); cnt++; hit = hs_on; end
    check("hs_pulse_seen", int'(hit), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_hs", int'(hs_on), 0);
    check("async_rst_ls", int'(ls_on), 0);
    check("async_rst_state", int'(state), 0);
    check("async_rst_flags", int'({ss_done, fault}), 0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    check("post_rst_state", int'(state), 0);
    cycles(20);
    $display("mid-operation reset handled");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stepdown_corestate_ctrl.md
Name: stepdown_corestate_ctrl

Overview:
- Digital core-state controller for the step-down (buck) power stage.
- Generates complementary high-side/low-side gate-drive enables with dead-time.
- Sequences OFF -> SOFTSTART -> RUN and latches over-current faults.
- Outputs feed the inverter-brick gate-driver chain of the stepdown core; one instance per stepdown core.

Parameters:
- CNT_W, 8, width of PWM counter, period and duty fields.
- DEAD_CYC, 4, clocks both switches held off on each transition (≥1).
- SS_STEP_CYC, 64, clocks per 1-LSB soft-start duty increment (≥1).
- RETRY_CYC, 1024, fault hold-off clocks before auto-retry (used only with the retry feature).

Ports:
- clk  in  1  controller clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  converter enable, level.
- period  in  CNT_W  PWM period in clocks; sampled at counter wrap.
- duty_cmd  in  CNT_W  target high-side on-time in clocks; sampled at counter wrap.
- ocp  in  1  over-current comparator, pre-synchronised, active-high.
- hs_on  out  1  high-side drive enable.
- ls_on  out  1  low-side drive enable.
- state  out  2  00 OFF, 01 SOFTSTART, 10 RUN, 11 FAULT.
- ss_done  out  1  high while in RUN.
- fault  out  1  high while in FAULT.

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n. Reset values: state=OFF, hs_on=0, ls_on=0, ss_done=0, fault=0, counter=0, ss_duty=0, dead counter=0.
- All outputs are registered.
- PWM counter:
  - Counts 0..period_l-1, then wraps to 0. period_l and duty_l are latched at wrap.
  - period_l<2: both drives forced off and the counter is held at 0.
  - raw = (cnt < duty_eff), where duty_eff = min(duty_l, ss_limit, period_l).
  - ss_limit = ss_duty in SOFTSTART; ss_limit = all-ones in RUN.
- Dead-time:
  - On any change of raw, both drives go 0 on the next clock and stay 0 for DEAD_CYC clocks; then the side selected by raw asserts.
  - hs_on and ls_on are never 1 together, in any state or cycle.
  - A raw pulse shorter than DEAD_CYC produces no on-time for that side.
- Edge cases:
  - duty_eff ≥ period_l: hs_on stays 1 continuously after the initial dead-time, with no switching.
  - duty_eff = 0 in RUN: ls_on stays 1 continuously.
- FSM transitions (evaluated each clock):
  - OFF: en=1 -> SOFTSTART, with ss_duty=0 and counter=0.
  - SOFTSTART:
    - ss_duty increments every SS_STEP_CYC clocks, saturating at duty_l.
    - ls_on is suppressed while ss_duty=0, so both drives stay off.
    - When ss_duty ≥ duty_l, go to RUN.
  - RUN: normal switching; ss_done=1.
  - SOFTSTART/RUN with ocp=1 -> FAULT. Drives go 0 on the next clock with no dead-time wait.
  - FAULT: both drives 0; fault=1.
  - Any state with en=0 -> OFF next clock; drives 0; fault and ss_done cleared.
- Simultaneous events:
  - en=0 and ocp=1 in the same cycle -> OFF.
  - ocp=1 on the cycle SOFTSTART would enter RUN -> FAULT.
- Changes to duty_cmd and period mid-period take effect at the next wrap only.
- Asserting rst_n low mid-operation forces all outputs to 0 asynchronously, within the same cycle.

Optional Feature:
- Macro: STEPDOWN_FAULT_RETRY_EN.
- Defined:
  - FAULT runs a hold-off counter.
  - After RETRY_CYC clocks, and only if ocp=0 at that point, go to SOFTSTART with ss_duty=0.
  - If ocp=1 when the count completes, the counter restarts.
- Undefined: FAULT is held until en=0 (→ OFF); the RETRY_CYC parameter is unused.

Decomposition:
- Shared package stepdown_pkg holds:
  - the state_e enum (OFF/SOFTSTART/RUN/FAULT, 2-bit encoding as above);
  - the default constants for CNT_W, DEAD_CYC, SS_STEP_CYC and RETRY_CYC.
- One sub-module: stepdown_deadtime.
  - Inputs: raw, force_off. Outputs: hs_on, ls_on.
  - Owns the dead counter and the mutual-exclusion guarantee.
- The FSM, PWM counter and soft-start ramp stay in the top module.

Test Plan:
- Reset/enable: rst_n low, then en=1, period=100, duty_cmd=40, SS_STEP_CYC=2.
  - ss_duty reaches 40 after ~80 clocks, then state=10 and ss_done=1.
  - Thereafter hs_on is high 36 clocks per period, ls_on high 56 clocks per period, with 4-clock gaps.
- Dead-time/exclusivity: random duty_cmd 0..120 with period=100 over 10k cycles.
  - hs_on & ls_on is never 1.
  - Every hs_on/ls_on transition is separated by exactly DEAD_CYC zero cycles.
- Boundaries:
  - duty_cmd=100 with period=100: hs_on held 1 with no toggles.
  - duty_cmd=0: ls_on held 1.
  - period=1: both outputs stay 0.
- Fault: in RUN, pulse ocp for 1 cycle.
  - Next clock: hs_on=ls_on=0, state=11, fault=1.
  - en=0 then gives state=00 and fault=0.
- Retry (macro defined, RETRY_CYC=16):
  - ocp held high for 30 cycles: state stays 11.
  - ocp released: SOFTSTART is entered at the next 16-cycle boundary, with ss_duty=0.
- Mid-op reset: rst_n low during an hs_on=1 pulse.
  - Outputs go 0 without waiting for clk.
  - After release, state=00.
